vanilla_sb_stall_profiler: RTL and testbench



---
 rtl/vanilla_sb_stall_profiler.sv | 88 ++++++++
 tb/tb_vanilla_sb_stall_profiler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vanilla_sb_stall_profiler.sv
// vanilla_sb_stall_profiler: attributes dependency-stall cycles to scoreboard causes and dumps saturating counts
module vanilla_sb_stall_profiler #(
  parameter int counter_width_p = 32,
  parameter int reg_els_p = 32,
  parameter int reg_addr_width_p = 5
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [reg_els_p-1:0][5:0]            int_sb_i,
  input  logic [reg_els_p-1:0][3:0]            float_sb_i,
  input  logic                                 stall_depend_i,
  input  logic                                 stall_all_i,
  input  logic [reg_addr_width_p-1:0]          rs1_i,
  input  logic [reg_addr_width_p-1:0]          rs2_i,
  input  logic [reg_addr_width_p-1:0]          rd_i,
  input  logic [reg_addr_width_p-1:0]          rs3_i,
  input  logic                                 read_rs1_i,
  input  logic                                 read_rs2_i,
  input  logic                                 write_rd_i,
  input  logic                                 read_frs1_i,
  input  logic                                 read_frs2_i,
  input  logic                                 read_frs3_i,
  input  logic                                 write_frd_i,
  input  logic                                 dump_v_i,
  input  logic                                 dump_clear_i,
  output logic                                 dump_ready_o,
  output logic                                 dump_v_o,
  output logic [3:0]                           dump_idx_o,
  output logic [counter_width_p-1:0]           dump_data_o,
  input  logic                                 dump_yumi_i
);
  typedef enum logic {IDLE, DUMP} state_e;
  state_e state_q;
  logic [3:0] idx_q;
  logic clr_q;
  logic [5:0] int_hit;
  logic [3:0] float_hit;
  logic [9:0] hit;
  logic [10:0] inc;
  logic [counter_width_p-1:0] cnt_q [10:0];
  logic [counter_width_p-1:0] cnt_d [10:0];
  // x0 never holds a dependency, but float f0 is a real register
  always_comb begin
    int_hit = (read_rs1_i && rs1_i != '0 ? int_sb_i[rs1_i] : 6'd0)
            | (read_rs2_i && rs2_i != '0 ? int_sb_i[rs2_i] : 6'd0)
            | (write_rd_i && rd_i != '0 ? int_sb_i[rd_i] : 6'd0);
    float_hit = (read_frs1_i ? float_sb_i[rs1_i] : 4'd0)
              | (read_frs2_i ? float_sb_i[rs2_i] : 4'd0)
              | (read_frs3_i ? float_sb_i[rs3_i] : 4'd0)
              | (write_frd_i ? float_sb_i[rd_i] : 4'd0);
    hit = {float_hit, int_hit};
    inc = (stall_depend_i && !stall_all_i) ? {~|hit, hit & (~hit + 10'd1)} : 11'd0;
  end
  for (genvar g = 0; g < 11; g++) begin : g_cnt
    // clear-on-read wins over the old value but still keeps a same-cycle increment
    always_comb begin
      cnt_d[g] = (state_q == DUMP && dump_yumi_i && clr_q && idx_q == 4'(g))
               ? counter_width_p'(inc[g])
               : cnt_q[g] + counter_width_p'(inc[g] && !(&cnt_q[g]));
    end
    // per-cause saturating counter
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) cnt_q[g] <= '0;
      else cnt_q[g] <= cnt_d[g];
    end
  end
  // dump sequencer: walks idx 0..10, advancing one word per yumi
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      clr_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (dump_v_i) begin
        state_q <= DUMP;
        idx_q <= '0;
        clr_q <= dump_clear_i;
      end
    end else if (dump_yumi_i) begin
      state_q <= idx_q == 4'd10 ? IDLE : DUMP;
      idx_q <= idx_q == 4'd10 ? 4'd0 : idx_q + 4'd1;
    end
  end
  assign dump_ready_o = state_q == IDLE;
  assign dump_v_o = state_q == DUMP;
  assign dump_idx_o = idx_q;
  assign dump_data_o = state_q == DUMP ? cnt_q[idx_q] : '0;
endmodule

// File: tb/tb_vanilla_sb_stall_profiler.sv
// tb_vanilla_sb_stall_profiler: directed checks of attribution, saturation, dump protocol and reset
module tb_vanilla_sb_stall_profiler;
  logic clk = 1'b0;
  logic reset_i;
  logic [31:0][5:0] int_sb_i;
  logic [31:0][3:0] float_sb_i;
  logic stall_depend_i, stall_all_i;
  logic [4:0] rs1_i, rs2_i, rd_i, rs3_i;
  logic read_rs1_i, read_rs2_i, write_rd_i;
  logic read_frs1_i, read_frs2_i, read_frs3_i, write_frd_i;
  logic dump_v_i, dump_clear_i, dump_yumi_i;
  logic ready4, v4, ready32, v32;
  logic [3:0] idx4, idx32;
  logic [3:0] data4;
  logic [31:0] data32;
  int n_cmp = 0;
  int n_err = 0;
  int exp4 [11];
  int exp32 [11];

  always #5 clk = ~clk;

  vanilla_sb_stall_profiler #(.counter_width_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset_i), .int_sb_i(int_sb_i), .float_sb_i(float_sb_i),
    .stall_depend_i(stall_depend_i), .stall_all_i(stall_all_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .rs3_i(rs3_i),
    .read_rs1_i(read_rs1_i), .read_rs2_i(read_rs2_i), .write_rd_i(write_rd_i),
    .read_frs1_i(read_frs1_i), .read_frs2_i(read_frs2_i), .read_frs3_i(read_frs3_i),
    .write_frd_i(write_frd_i), .dump_v_i(dump_v_i), .dump_clear_i(dump_clear_i),
    .dump_ready_o(ready4), .dump_v_o(v4), .dump_idx_o(idx4), .dump_data_o(data4),
    .dump_yumi_i(dump_yumi_i));

  vanilla_sb_stall_profiler dut32 (
    .clk_i(clk), .reset_i(reset_i), .int_sb_i(int_sb_i), .float_sb_i(float_sb_i),
    .stall_depend_i(stall_depend_i), .stall_all_i(stall_all_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .rs3_i(rs3_i),
    .read_rs1_i(read_rs1_i), .read_rs2_i(read_rs2_i), .write_rd_i(write_rd_i),
    .read_frs1_i(read_frs1_i), .read_frs2_i(read_frs2_i), .read_frs3_i(read_frs3_i),
    .write_frd_i(write_frd_i), .dump_v_i(dump_v_i), .dump_clear_i(dump_clear_i),
    .dump_ready_o(ready32), .dump_v_o(v32), .dump_idx_o(idx32), .dump_data_o(data32),
    .dump_yumi_i(dump_yumi_i));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump(input int c);
    exp4[c] = exp4[c] == 15 ? 15 : exp4[c] + 1;
    exp32[c] = exp32[c] + 1;
  endtask

  task automatic zero_exp();
    for (int i = 0; i < 11; i++) begin
      exp4[i] = 0;
      exp32[i] = 0;
    end
  endtask

  task automatic clr_in();
    int_sb_i = '0; float_sb_i = '0;
    rs1_i = '0; rs2_i = '0; rd_i = '0; rs3_i = '0;
    read_rs1_i = 0; read_rs2_i = 0; write_rd_i = 0;
    read_frs1_i = 0; read_frs2_i = 0; read_frs3_i = 0; write_frd_i = 0;
  endtask

  task automatic stall(input int c, input int n);
    stall_depend_i = 1;
    for (int k = 0; k < n; k++) begin
      step();
      bump(c);
    end
    stall_depend_i = 0;
  endtask

  task automatic dump(input bit clr, input int hold, input int stall_at);
    dump_v_i = 1; dump_clear_i = clr;
    step();
    dump_v_i = 0; dump_clear_i = 0;
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("hold%0d_v", h), 32'(v4), 1);
      chk($sformatf("hold%0d_idx", h), 32'(idx4), 0);
      chk($sformatf("hold%0d_data", h), 32'(data4), exp4[0]);
      step();
    end
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("w%0d_v", i), 32'(v4 & v32), 1);
      chk($sformatf("w%0d_idx", i), 32'(idx4), i);
      chk($sformatf("w%0d_data4", i), 32'(data4), exp4[i]);
      chk($sformatf("w%0d_data32", i), data32, exp32[i]);
      dump_yumi_i = 1;
      if (i == stall_at) stall_depend_i = 1;
      step();
      if (clr) begin
        exp4[i] = 0;
        exp32[i] = 0;
      end
      if (i == stall_at) begin
        stall_depend_i = 0;
        bump(4);
      end
    end
    dump_yumi_i = 0;
    chk("end_ready", 32'(ready4 & ready32), 1);
    chk("end_v", 32'(v4 | v32), 0);
  endtask

  initial begin
    clr_in();
    reset_i = 1; stall_depend_i = 0; stall_all_i = 0;
    dump_v_i = 0; dump_clear_i = 0; dump_yumi_i = 0;
    zero_exp();
    repeat (2) step();
    chk("rst_ready", 32'(ready4 & ready32), 1);
    chk("rst_v", 32'(v4 | v32), 0);
    chk("rst_idx", 32'(idx4 | idx32), 0);
    chk("rst_data", data32 | 32'(data4), 0);
    reset_i = 0;
    step();
    rs1_i = 3; read_rs1_i = 1; int_sb_i[3][1] = 1;
    stall(1, 5);
    dump(1, 0, -1);
    clr_in();
    rs2_i = 2; read_rs2_i = 1; int_sb_i[2][0] = 1;
    rs1_i = 4; read_frs1_i = 1; float_sb_i[4][0] = 1;
    stall(0, 3);
    stall_all_i = 1; stall_depend_i = 1;
    repeat (2) step();
    stall_all_i = 0; stall_depend_i = 0;
    dump(1, 0, -1);
    clr_in();
    rs1_i = 0; read_rs1_i = 1; int_sb_i[0] = 6'h3f;
    stall(10, 4);
    clr_in();
    rd_i = 9; write_rd_i = 1; int_sb_i[9][5] = 1;
    stall(5, 2);
    clr_in();
    rs3_i = 6; read_frs3_i = 1; float_sb_i[6][3] = 1;
    stall(9, 2);
    clr_in();
    rs2_i = 0; read_frs2_i = 1; float_sb_i[0][2] = 1;
    stall(8, 1);
    clr_in();
    rs1_i = 5; read_rs1_i = 1; int_sb_i[5][4] = 1;
    dump(1, 3, 4);
    clr_in();
    dump(1, 0, -1);
    rs1_i = 7; read_frs1_i = 1; float_sb_i[7][1] = 1;
    stall(7, 20);
    clr_in();
    dump(0, 0, -1);
    dump_v_i = 1;
    step();
    dump_v_i = 0;
    dump_yumi_i = 1;
    repeat (5) step();
    dump_yumi_i = 0;
    chk("pre_rst_idx", 32'(idx4), 5);
    reset_i = 1;
    #1;
    chk("mid_rst_v", 32'(v4 | v32), 0);
    chk("mid_rst_ready", 32'(ready4 & ready32), 1);
    step();
    reset_i = 0;
    zero_exp();
    step();
    chk("post_rst_v", 32'(v4 | v32), 0);
    dump(0, 0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
